// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the device, issues a request-to-send,
// then shifts a command byte out on device clock falls and collects the ACK bit.
module ps2_host_tx #(
    parameter int CLOCK_HOLD_CYCLES  = 10000,
    parameter int START_SETUP_CYCLES = 64,
    parameter int FILTER_LEN         = 8,
    parameter int TIMEOUT_CYCLES     = 1250000
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    output logic       ps2_external_clock_pulldown,
    output logic       ps2_external_data_pulldown,
    input  logic       ps2_external_clock_in,
    input  logic       ps2_external_data_in
);

    localparam int MAX_AB  = (CLOCK_HOLD_CYCLES > START_SETUP_CYCLES) ? CLOCK_HOLD_CYCLES : START_SETUP_CYCLES;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(CLOCK_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST   = CW'(START_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic [9:0]    frame, frame_n;
    logic          ack_ok, ack_ok_n;
    logic          done_n, error_n, data_pd_n;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt_clk, filt_dat, fall;
    logic [FW-1:0] clk_fcnt, dat_fcnt;

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_external_clock_in};
            dat_sync <= {dat_sync[0], ps2_external_data_in};
        end
    end

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            clk_fcnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FILT_LAST) begin
                filt_clk <= clk_sync[1];
                clk_fcnt <= '0;
                fall     <= filt_clk;
            end else begin
                clk_fcnt <= clk_fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            filt_dat <= 1'b1;
            dat_fcnt <= '0;
        end else begin
            if (dat_sync[1] == filt_dat) begin
                dat_fcnt <= '0;
            end else if (dat_fcnt == FILT_LAST) begin
                filt_dat <= dat_sync[1];
                dat_fcnt <= '0;
            end else begin
                dat_fcnt <= dat_fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state                       <= IDLE;
            cnt                         <= '0;
            idx                         <= '0;
            frame                       <= '0;
            ack_ok                      <= 1'b0;
            tx_ready                    <= 1'b1;
            tx_done                     <= 1'b0;
            tx_error                    <= 1'b0;
            rx_inhibit                  <= 1'b0;
            ps2_external_clock_pulldown <= 1'b0;
            ps2_external_data_pulldown  <= 1'b0;
        end else begin
            state                       <= state_n;
            cnt                         <= cnt_n;
            idx                         <= idx_n;
            frame                       <= frame_n;
            ack_ok                      <= ack_ok_n;
            tx_ready                    <= (state_n == IDLE);
            tx_done                     <= done_n;
            tx_error                    <= error_n;
            rx_inhibit                  <= (state_n != IDLE);
            ps2_external_clock_pulldown <= (state_n == INHIBIT) || (state_n == REQUEST);
            ps2_external_data_pulldown  <= data_pd_n;
        end
    end

    // The same counter times the inhibit/request phases and then serves as the
    // watchdog between device clock falls; it saturates rather than wrapping.
    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        idx_n     = idx;
        frame_n   = frame;
        ack_ok_n  = ack_ok;
        done_n    = 1'b0;
        error_n   = 1'b0;
        data_pd_n = ps2_external_data_pulldown;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                data_pd_n = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_n = {1'b1, ~^tx_data, tx_data};
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n     = '0;
                    data_pd_n = 1'b1;
                    state_n   = REQUEST;
                end
            end
            REQUEST: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (fall) begin
                    cnt_n     = '0;
                    data_pd_n = ~frame[idx];
                    if (idx == 4'd9) begin
                        state_n = ACK;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    cnt_n    = '0;
                    ack_ok_n = ~filt_dat;
                    state_n  = RELEASE;
                end
            end
            RELEASE: begin
                if (fall) begin
                    cnt_n = '0;
                end
                if (filt_clk && filt_dat) begin
                    done_n    = 1'b1;
                    error_n   = ~ack_ok;
                    data_pd_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if ((state == SEND || state == ACK || state == RELEASE) && state_n == state
            && !fall && cnt == TIMEOUT_LAST) begin
            done_n    = 1'b1;
            error_n   = 1'b1;
            data_pd_n = 1'b0;
            state_n   = IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model on wired-AND lines
// plus a frame/parity reference model, table vectors and random transfers.
module tb_ps2_host_tx;

    localparam int HOLD    = 40;
    localparam int SETUP   = 8;
    localparam int FILT    = 4;
    localparam int TIMEOUT = 400;
    localparam int HALF    = 20;

    logic       main_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic       clk_pd, dat_pd;
    logic       dev_clk, dev_dat;
    logic       clk_line, dat_line;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    int done_wide = 0;
    logic last_err = 1'b0;
    logic done_ready = 1'b0;
    logic prev_done = 1'b0;
    int rel_cyc = 0;

    assign clk_line = !clk_pd && dev_clk;
    assign dat_line = !dat_pd && dev_dat;

    ps2_host_tx #(
        .CLOCK_HOLD_CYCLES(HOLD),
        .START_SETUP_CYCLES(SETUP),
        .FILTER_LEN(FILT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .main_clk(main_clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .rx_inhibit(rx_inhibit),
        .ps2_external_clock_pulldown(clk_pd),
        .ps2_external_data_pulldown(dat_pd),
        .ps2_external_clock_in(clk_line),
        .ps2_external_data_in(dat_line)
    );

    always #5 main_clk = ~main_clk;

    always @(posedge main_clk) cyc <= cyc + 1;

    always @(negedge main_clk) begin
        if (tx_done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
            last_err   = tx_error;
            done_ready = tx_ready;
            if (prev_done) done_wide = done_wide + 1;
        end
        prev_done = tx_done;
    end

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] stopped");
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_parity;
        logic       exp_error;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_err = n_err + 1;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge main_clk);
    endtask

    // Reference frame: data LSB first, odd parity, stop bit.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            f[i] = (b >> i) & 8'd1;
            ones = ones + int'(f[i]);
        end
        f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Handshake one byte and measure the inhibit / request-to-send timing.
    task automatic apply_stimulus(input logic [7:0] data);
        int k;
        int data_off;
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge main_clk);
        tx_valid = 1'b0;
        check_output("accept_ready_low", tx_ready, 0);
        check_output("accept_inhibit", rx_inhibit, 1);
        check_output("accept_clk_pd", clk_pd, 1);
        k = 0;
        data_off = -1;
        while (clk_pd && k < 1000) begin
            if (dat_pd && data_off < 0) data_off = k;
            k = k + 1;
            @(negedge main_clk);
        end
        rel_cyc = cyc;
        check_output("clk_hold_len", k, HOLD + SETUP);
        check_output("data_fall_offset", data_off, HOLD);
    endtask

    task automatic device_bfm(input logic ack, input int glitch_after, input int busy_after,
                              input int reset_after, output logic [9:0] bits, output logic aborted);
        aborted = 1'b0;
        bits = '0;
        wait_cycles(30);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_dat = ack ? 1'b0 : 1'b1;
                wait_cycles(5);
            end
            dev_clk = 1'b0;
            if (i == reset_after) begin
                wait_cycles(12);
                reset = 1'b1;
                #1;
                check_output("reset_clk_pd", clk_pd, 0);
                check_output("reset_dat_pd", dat_pd, 0);
                check_output("reset_inhibit", rx_inhibit, 0);
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                aborted = 1'b1;
                return;
            end
            wait_cycles(HALF);
            if (i <= 10) bits[i-1] = dat_line;
            dev_clk = 1'b1;
            if (i == busy_after) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                wait_cycles(2);
                tx_valid = 1'b0;
                wait_cycles(HALF - 2);
            end else if (i == glitch_after) begin
                wait_cycles(5);
                dev_clk = 1'b0;
                wait_cycles(3);
                dev_clk = 1'b1;
                wait_cycles(HALF - 8);
            end else begin
                wait_cycles(HALF);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input int prev, input int limit);
        int k = 0;
        while (done_count == prev && k < limit) begin
            @(negedge main_clk);
            k = k + 1;
        end
        check_output("done_count", done_count, prev + 1);
    endtask

    task automatic run_transfer(input logic [7:0] data, input logic ack, input int glitch_after,
                                input int busy_after, output logic [9:0] bits, output logic err);
        int prev;
        logic aborted;
        prev = done_count;
        apply_stimulus(data);
        device_bfm(ack, glitch_after, busy_after, 0, bits, aborted);
        wait_done(prev, 200);
        check_output("ready_at_done", done_ready, 1);
        err = last_err;
        wait_cycles(5);
    endtask

    initial begin
        vec_t vecs[6];
        logic [9:0] bits;
        logic [9:0] exp;
        logic err;
        logic aborted;
        logic [7:0] rb;
        logic ra;
        int prev;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hED, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'hF3, 1'b1, 1'b1, 1'b0};

        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        wait_cycles(3);
        check_output("rst_ready", tx_ready, 1);
        check_output("rst_done", tx_done, 0);
        check_output("rst_error", tx_error, 0);
        check_output("rst_inhibit", rx_inhibit, 0);
        check_output("rst_clk_pd", clk_pd, 0);
        check_output("rst_dat_pd", dat_pd, 0);
        reset = 1'b0;
        wait_cycles(3);

        for (int v = 0; v < 6; v++) begin
            run_transfer(vecs[v].data, vecs[v].ack, 0, 0, bits, err);
            check_output("vec_data_bits", bits[7:0], vecs[v].data);
            check_output("vec_parity", bits[8], vecs[v].exp_parity);
            check_output("vec_stop", bits[9], 1);
            check_output("vec_error", err, vecs[v].exp_error);
        end

        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            run_transfer(rb, ra, 0, 0, bits, err);
            exp = model_frame(rb);
            check_output("rand_frame", bits, exp);
            check_output("rand_error", err, !ra);
        end

        run_transfer(8'hED, 1'b1, 3, 5, bits, err);
        check_output("glitch_busy_frame", bits, model_frame(8'hED));
        check_output("glitch_busy_error", err, 0);
        wait_cycles(40);
        check_output("busy_not_latched_idle", rx_inhibit, 0);

        prev = done_count;
        apply_stimulus(8'h12);
        wait_done(prev, TIMEOUT + 100);
        check_output("timeout_latency", done_cyc - rel_cyc, TIMEOUT);
        check_output("timeout_error", last_err, 1);
        @(negedge main_clk);
        check_output("timeout_clk_pd", clk_pd, 0);
        check_output("timeout_dat_pd", dat_pd, 0);
        wait_cycles(5);

        prev = done_count;
        apply_stimulus(8'h55);
        device_bfm(1'b1, 0, 0, 4, bits, aborted);
        check_output("reset_aborted", aborted, 1);
        wait_cycles(2);
        reset = 1'b0;
        @(negedge main_clk);
        check_output("reset_ready_after", tx_ready, 1);
        wait_cycles(60);
        check_output("reset_no_done", done_count, prev);

        run_transfer(8'hF3, 1'b1, 0, 0, bits, err);
        check_output("after_reset_frame", bits, model_frame(8'hF3));
        check_output("after_reset_error", err, 0);

        check_output("done_single_cycle", done_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
